// File: rtl/lorenz_pkg.sv
// Shared types and saturating arithmetic helpers for the Lorenz Euler stepper.
// Arithmetic is carried at CalcW bits and clipped once to the target word width.
package lorenz_pkg;

    localparam int unsigned CalcW = 64;

    typedef logic signed [CalcW-1:0] calc_t;

    typedef enum logic [2:0] {
        StIdle,
        StM1,
        StM2,
        StM3,
        StM4,
        StUpd
    } state_e;

    // Largest positive value of a w-bit two's complement word.
    function automatic calc_t sat_max(input int unsigned w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    // Most negative value of a w-bit two's complement word.
    function automatic calc_t sat_min(input int unsigned w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    function automatic calc_t sat_clip(
        input  calc_t       v,
        input  int unsigned w,
        output logic        clipped
    );
        calc_t r;
        r       = v;
        clipped = 1'b0;
        if (v > sat_max(w)) begin
            r       = sat_max(w);
            clipped = 1'b1;
        end else if (v < sat_min(w)) begin
            r       = sat_min(w);
            clipped = 1'b1;
        end
        return r;
    endfunction

    function automatic calc_t sat_add(
        input  calc_t       a,
        input  calc_t       b,
        input  int unsigned w,
        output logic        clipped
    );
        return sat_clip(a + b, w, clipped);
    endfunction

    function automatic calc_t sat_sub(
        input  calc_t       a,
        input  calc_t       b,
        input  int unsigned w,
        output logic        clipped
    );
        return sat_clip(a - b, w, clipped);
    endfunction

endpackage

// File: rtl/fx_sat_mult.sv
// Combinational signed fixed-point multiplier: keeps bits [FRAC+WIDTH-1:FRAC] of the
// full product and saturates when the discarded high bits are not a sign extension.
module fx_sat_mult
    import lorenz_pkg::*;
#(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned FRAC  = 20
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p,
    output logic                    ovf
);

    localparam int unsigned ProdW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));

    logic signed [ProdW-1:0] full;
    logic signed [ProdW-1:0] shifted;
    logic signed [WIDTH-1:0] mid;
    logic                    fits;

    assign full    = ProdW'(a) * ProdW'(b);
    assign shifted = full >>> FRAC;
    assign mid     = shifted[WIDTH-1:0];
    // The kept window fits iff re-extending it reproduces the whole shifted product.
    assign fits    = (shifted == ProdW'(mid));

    always_comb begin
        p   = mid;
        ovf = 1'b0;
        if (!fits) begin
            p   = full[ProdW-1] ? SatMin : SatMax;
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/lorenz_stepper.sv
// Time-multiplexed forward-Euler Lorenz solver: four products per step on one shared
// multiplier (M1..M4), then a single-edge update of x/y/z in UPD.
module lorenz_stepper
    import lorenz_pkg::*;
#(
    parameter int unsigned WIDTH    = 27,
    parameter int unsigned FRAC     = 20,
    parameter int unsigned DT_SHIFT = 8,
    parameter int unsigned STEP_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [STEP_W-1:0]        num_steps,
    input  logic signed [WIDTH-1:0]  sigma,
    input  logic signed [WIDTH-1:0]  beta,
    input  logic signed [WIDTH-1:0]  rho,
    input  logic signed [WIDTH-1:0]  x0,
    input  logic signed [WIDTH-1:0]  y0,
    input  logic signed [WIDTH-1:0]  z0,
    output logic signed [WIDTH-1:0]  x,
    output logic signed [WIDTH-1:0]  y,
    output logic signed [WIDTH-1:0]  z,
    output logic                     out_valid,
    output logic                     done,
    output logic                     busy,
    output logic                     ovf
);

    state_e                  state_q, state_d;
    logic [STEP_W-1:0]       cnt_q, cnt_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, p4_q, p4_d;
    logic                    valid_q, valid_d, done_q, done_d;
    logic                    busy_q, busy_d, ovf_q, ovf_d;

    logic signed [WIDTH-1:0] dx, dy, dz;
    logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
    logic                    mul_ovf, op_clip;
    logic signed [WIDTH-1:0] x_upd, y_upd, z_upd;
    logic                    x_clip, y_clip, z_clip;

    assign dx = x_q >>> DT_SHIFT;
    assign dy = y_q >>> DT_SHIFT;
    assign dz = z_q >>> DT_SHIFT;

    // Operand select for the shared multiplier; subtractions saturate before multiply.
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        op_clip = 1'b0;
        unique case (state_q)
            StM1: begin
                mul_a = sigma;
                mul_b = WIDTH'(sat_sub(calc_t'(dy), calc_t'(dx), WIDTH, op_clip));
            end
            StM2: begin
                mul_a = dx;
                mul_b = WIDTH'(sat_sub(calc_t'(rho), calc_t'(z_q), WIDTH, op_clip));
            end
            StM3: begin
                mul_a = dx;
                mul_b = y_q;
            end
            StM4: begin
                mul_a = dz;
                mul_b = beta;
            end
            default: ;
        endcase
    end

    fx_sat_mult #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    // Three-operand sums are formed wide and clipped once.
    always_comb begin
        x_clip = 1'b0;
        y_clip = 1'b0;
        z_clip = 1'b0;
        x_upd  = WIDTH'(sat_add(calc_t'(x_q), calc_t'(p1_q), WIDTH, x_clip));
        y_upd  = WIDTH'(sat_clip(calc_t'(y_q) + calc_t'(p2_q) - calc_t'(dy), WIDTH, y_clip));
        z_upd  = WIDTH'(sat_clip(calc_t'(z_q) + calc_t'(p3_q) - calc_t'(p4_q), WIDTH, z_clip));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        p4_d    = p4_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d   = x0;
                    y_d   = y0;
                    z_d   = z0;
                    cnt_d = num_steps;
                    ovf_d = 1'b0;
                    if (num_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StM1;
                        busy_d  = 1'b1;
                    end
                end
            end
            StM1: begin
                p1_d    = mul_p;
                ovf_d   = ovf_q | mul_ovf | op_clip;
                state_d = StM2;
            end
            StM2: begin
                p2_d    = mul_p;
                ovf_d   = ovf_q | mul_ovf | op_clip;
                state_d = StM3;
            end
            StM3: begin
                p3_d    = mul_p;
                ovf_d   = ovf_q | mul_ovf;
                state_d = StM4;
            end
            StM4: begin
                p4_d    = mul_p;
                ovf_d   = ovf_q | mul_ovf;
                state_d = StUpd;
            end
            StUpd: begin
                x_d     = x_upd;
                y_d     = y_upd;
                z_d     = z_upd;
                ovf_d   = ovf_q | x_clip | y_clip | z_clip;
                valid_d = 1'b1;
                cnt_d   = cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = StM1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            p4_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            p4_q    <= p4_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_lorenz_stepper.sv
// Directed, table-driven bench for lorenz_stepper with hand-computed expected states.
module tb_lorenz_stepper;

    localparam int unsigned W      = 27;
    localparam int unsigned STEP_W = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [STEP_W-1:0]     num_steps;
    logic signed [W-1:0]   sigma, beta, rho, x0, y0, z0;
    logic signed [W-1:0]   x, y, z;
    logic                  out_valid, done, busy, ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [W-1:0] sx[8];
    logic signed [W-1:0] sy[8];
    logic signed [W-1:0] sz[8];

    always #5 clk = ~clk;

    lorenz_stepper #(
        .WIDTH    (W),
        .FRAC     (20),
        .DT_SHIFT (8),
        .STEP_W   (STEP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_steps (num_steps),
        .sigma     (sigma),
        .beta      (beta),
        .rho       (rho),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .done      (done),
        .busy      (busy),
        .ovf       (ovf)
    );

    typedef struct {
        logic signed [W-1:0] sigma, rho, beta, x0, y0, z0;
        int                  steps;
        logic signed [W-1:0] ex, ey, ez;
        logic                eovf;
    } vec_t;

    vec_t tbl[5];

    function automatic vec_t mk(input logic signed [W-1:0] s, r, b, ix, iy, iz,
                                input int n, input logic signed [W-1:0] ex, ey, ez,
                                input logic eo);
        vec_t v;
        v.sigma = s;  v.rho = r;  v.beta = b;
        v.x0 = ix;    v.y0 = iy;  v.z0 = iz;
        v.steps = n;
        v.ex = ex;    v.ey = ey;  v.ez = ez;
        v.eovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        sigma = 27'sh0A00000;
        rho   = 27'sh1C00000;
        beta  = 27'sh02AAAAB;
        x0    = 27'sh0100000;
        y0    = '0;
        z0    = '0;
    endtask

    // Starts a run, follows it to done (bounded), checks timing and final state.
    task automatic do_run(input vec_t v, input string tag);
        int                  cyc, nvalid, unstable;
        bit                  got;
        logic signed [W-1:0] px;
        sigma = v.sigma;  rho = v.rho;  beta = v.beta;
        x0 = v.x0;        y0 = v.y0;    z0 = v.z0;
        num_steps = v.steps[STEP_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;  nvalid = 0;  unstable = 0;  got = 1'b0;
        chk({tag, "_ovf_cleared"}, ovf, 0);
        chk({tag, "_busy_after_start"}, busy, (v.steps > 0));
        px = x;
        while (!got && cyc <= 5 * v.steps + 10) begin
            if (out_valid) begin
                if (nvalid < 8) begin
                    sx[nvalid] = x;  sy[nvalid] = y;  sz[nvalid] = z;
                end
                nvalid++;
                chk({tag, "_valid_cycle"}, cyc, 5 * nvalid);
            end else if (cyc > 0 && x !== px) begin
                unstable++;
            end
            px = x;
            if (done) begin
                got = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_done_cycle"}, cyc, 5 * v.steps);
        chk({tag, "_valid_with_done"}, out_valid, (v.steps > 0));
        chk({tag, "_valid_count"}, nvalid, v.steps);
        chk({tag, "_x"}, x, v.ex);
        chk({tag, "_y"}, y, v.ey);
        chk({tag, "_z"}, z, v.ez);
        chk({tag, "_ovf"}, ovf, v.eovf);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_x_stable"}, unstable, 0);
    endtask

    initial begin
        int seen;
        reset = 1'b0;
        start = 1'b0;
        num_steps = '0;
        set_defaults();
        tick();
        tick();
        chk("reset_x", x, 0);
        chk("reset_y", y, 0);
        chk("reset_z", z, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", ovf, 0);
        reset = 1'b1;
        tick();

        // single step; three steps; saturating step; back-to-back single; zero steps
        tbl[0] = mk(27'sh0A00000, 27'sh1C00000, 27'sh02AAAAB, 27'sh0100000, '0, '0,
                    1, 27'sd1007616, 27'sd114688, 27'sd0, 1'b0);
        tbl[1] = mk(27'sh0A00000, 27'sh1C00000, 27'sh02AAAAB, 27'sh0100000, '0, '0,
                    3, 27'sd943506, 27'sd329942, 27'sd1241, 1'b0);
        tbl[2] = mk(27'sh0A00000, 27'sh3FFFFFF, 27'sh02AAAAB, 27'sh3FFFFFF, 27'sh3FFFFFF, '0,
                    1, 27'sd67108863, 27'sd67108863, 27'sd16777151, 1'b1);
        tbl[3] = mk(27'sh0A00000, 27'sh1C00000, 27'sh02AAAAB, 27'sh0100000, '0, '0,
                    1, 27'sd1007616, 27'sd114688, 27'sd0, 1'b0);
        tbl[4] = mk(27'sh0A00000, 27'sh1C00000, 27'sh02AAAAB, 27'sh0012345, -27'sd5, 27'sd7,
                    0, 27'sh0012345, -27'sd5, 27'sd7, 1'b0);

        // Each entry starts in the done cycle of the previous one.
        for (int i = 0; i < 5; i++) begin
            do_run(tbl[i], $sformatf("vec%0d", i));
            if (i == 1) begin
                chk("multi_s1_x", sx[0], 1007616);
                chk("multi_s1_y", sy[0], 114688);
                chk("multi_s1_z", sz[0], 0);
                chk("multi_s2_x", sx[1], 972736);
                chk("multi_s2_y", sy[1], 224448);
                chk("multi_s2_z", sz[1], 430);
            end
            if (i == 2) begin
                tick();
                tick();
                chk("sat_ovf_sticky", ovf, 1);
            end
        end
        tick();
        chk("zero_done_one_cycle", done, 0);
        chk("zero_no_valid", out_valid, 0);

        // Start pulsed during M3 must be ignored.
        set_defaults();
        num_steps = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        num_steps = 16'd5;
        x0 = 27'sd123;
        tick();
        start = 1'b0;
        x0 = 27'sh0100000;
        tick();
        chk("ign_no_early_done", done, 0);
        tick();
        chk("ign_done", done, 1);
        chk("ign_valid", out_valid, 1);
        chk("ign_x", x, 1007616);
        chk("ign_y", y, 114688);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid || done || busy) seen++;
        end
        chk("ign_no_extra_activity", seen, 0);

        // Reset during M2 of step 2 aborts silently.
        set_defaults();
        num_steps = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_x", x, 0);
        chk("rst_mid_y", y, 0);
        chk("rst_mid_z", z, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_valid", out_valid, 0);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || out_valid || busy) seen++;
        end
        chk("rst_mid_quiet", seen, 0);
        do_run(tbl[0], "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lorenz_stepper.md
Name: lorenz_stepper

Overview:
- Parametrised, time-multiplexed forward-Euler solver for the Lorenz system, in fixed-point two's complement.
- Uses one shared signed multiplier for four products per step, with saturating arithmetic.
- Runs a host-programmed number of steps from a start/done handshake and emits a per-step valid strobe.
- Sits between the host-side parameter registers and the trajectory sink (DAC/VGA plotter) of the ODE solver datapath.

Parameters:
- WIDTH, 27, total bits of every state/coefficient word.
- FRAC, 20, fractional bits (default 7.20 format).
- DT_SHIFT, 8, time step dt = 2^-DT_SHIFT, applied by arithmetic right shift.
- STEP_W, 16, width of the step counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_steps  in  STEP_W  Euler steps to run; sampled with start.
- sigma, beta, rho  in  WIDTH each  coefficients; must be stable while busy.
- x0, y0, z0  in  WIDTH each  initial state; sampled with start.
- x, y, z  out  WIDTH each  registered current state.
- out_valid  out  1  one-cycle pulse when x/y/z hold a new step result.
- done  out  1  one-cycle pulse when the run completes.
- busy  out  1  high from the cycle after start acceptance until done.
- ovf  out  1  sticky saturation flag; cleared on start acceptance.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; x=y=z=0; out_valid=done=busy=ovf=0; counter=0; product regs=0. Reset has priority in any state and aborts a run immediately, with no done pulse.
- FSM states: IDLE, M1, M2, M3, M4, UPD.
- IDLE, on start:
  - load x<=x0, y<=y0, z<=z0; cnt<=num_steps; clear ovf.
  - if num_steps==0: stay IDLE and pulse done next cycle, with busy remaining 0 and no out_valid.
  - else go to M1 with busy<=1.
- start outside IDLE is ignored.
- Shifts: dx=x>>>DT_SHIFT, dy=y>>>DT_SHIFT, dz=z>>>DT_SHIFT.
- Product schedule, one product registered per state:
  - M1: p1 = sigma*(dy-dx)
  - M2: p2 = dx*(rho-z)
  - M3: p3 = dx*y
  - M4: p4 = dz*beta
- Multiply rule:
  - full 2*WIDTH signed product, result = bits [FRAC+WIDTH-1:FRAC];
  - if the discarded high bits are not a sign extension of the result MSB, saturate to +max (2^(WIDTH-1)-1) or -max (-2^(WIDTH-1)) by product sign and set ovf.
- All add/sub operations (dy-dx, rho-z, state updates) saturate to the same bounds and set ovf on clipping.
- UPD, single edge, all three states updated from pre-update values:
  - x<=x+p1; y<=y+p2-dy; z<=z+p3-p4.
  - Intermediate sums are computed at WIDTH+2 bits and saturated once.
  - out_valid<=1; cnt<=cnt-1.
  - if cnt==1: state<=IDLE, done<=1, busy<=0; else state<=M1.
- Timing: start sampled at edge k → out_valid high after edges k+5, k+10, …, k+5N. done is coincident with the last out_valid. x/y/z are stable between UPD edges.
- A start in the same cycle as done (state already IDLE) is accepted.

Decomposition:
- Shared package lorenz_pkg holds:
  - saturation bound constants derived from WIDTH;
  - FSM state enum;
  - the sat_add/sat_sub functions.
- One sub-module, fx_sat_mult (WIDTH, FRAC), holds the combinational signed multiply with bit selection and overflow detect. The FSM, counter and state registers live in lorenz_stepper.

Test Plan:
- Single step, defaults. Inputs: sigma=0xA00000 (10), rho=0x1C00000 (28), beta=0x2AAAAB, x0=0x100000, y0=0, z0=0, num_steps=1. Required: one out_valid and done at edge k+5; x=1007616, y=114688, z=0, ovf=0.
- Multi-step. Same inputs, num_steps=3. Required: out_valid at k+5, k+10, k+15; done only at k+15; busy high k+1..k+15; values match the bit-accurate C model.
- Saturation. Inputs: x0=0x3FFFFFF, y0=0x3FFFFFF, z0=0, rho=0x3FFFFFF, num_steps=1. Required: y=0x3FFFFFF (clipped), ovf=1, held until next start.
- Zero steps / ignored start. num_steps=0 → done one cycle after start, x/y/z=x0/y0/z0, no out_valid. A start pulsed during M3 of a run leaves the step count and results unchanged.
- Reset mid-run. Assert reset during M2 of step 2. Required: x=y=z=0, busy=0, no done. A fresh start then reproduces the step-1 result.
- Back-to-back. Raise start in the done cycle. Required: a new run is accepted, ovf cleared, first out_valid 5 cycles later.
